// File: rtl/redirection_ctrl_gen.sv
// EX-stage operand forwarding select generator with load-use stall detection.
// Tracks EX/MEM destination info, registers the select so it lines up with the instruction in EX.
module redirection_ctrl_gen #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [3:0]       redirection_ctrl,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr_reg;
    } prod_t;

    // The load flag only matters in EX; by MEM the result is already on mem_out.
    prod_t            r_ex_e;
    logic             r_ex_load;
    prod_t            r_mem_e;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_match_ex_rs, w_match_ex_rt;
    logic       w_match_mem_rs, w_match_mem_rt;
    logic       w_stall;
    logic       w_kill;
    prod_t      w_ex_nxt;
    logic       w_ex_load_nxt;
    logic [3:0] w_ctrl_nxt;

    function automatic logic f_match(input prod_t e, input logic vld, input logic use_src,
                                     input logic [REG_W-1:0] src);
        return vld & use_src & e.valid & e.wr_en & (e.wr_reg == src) & (src != '0);
    endfunction

    assign w_match_ex_rs  = f_match(r_ex_e,  id_valid, id_use_rs, id_rs);
    assign w_match_ex_rt  = f_match(r_ex_e,  id_valid, id_use_rt, id_rt);
    assign w_match_mem_rs = f_match(r_mem_e, id_valid, id_use_rs, id_rs);
    assign w_match_mem_rt = f_match(r_mem_e, id_valid, id_use_rt, id_rt);

    assign w_stall = ~flush & r_ex_load & (w_match_ex_rs | w_match_ex_rt);
    assign w_kill  = flush | w_stall;

    always_comb begin
        w_ex_nxt      = '0;
        w_ex_load_nxt = 1'b0;
        w_ctrl_nxt    = 4'b0000;
        if (!w_kill) begin
            w_ex_nxt.valid  = id_valid;
            w_ex_nxt.wr_en  = id_wr_en;
            w_ex_nxt.wr_reg = id_wr_reg;
            w_ex_load_nxt   = id_is_load;
            // EX match masks MEM match: the youngest producer wins.
            w_ctrl_nxt = {w_match_mem_rt & ~w_match_ex_rt, w_match_ex_rt,
                          w_match_mem_rs & ~w_match_ex_rs, w_match_ex_rs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_e      <= '0;
            r_ex_load   <= 1'b0;
            r_mem_e     <= '0;
            r_ctrl      <= 4'b0000;
            r_stall_cnt <= '0;
        end else begin
            r_mem_e   <= r_ex_e;
            r_ex_e    <= w_ex_nxt;
            r_ex_load <= w_ex_load_nxt;
            r_ctrl    <= w_ctrl_nxt;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign redirection_ctrl = r_ctrl;
    assign stall            = w_stall;
    assign stall_count      = r_stall_cnt;

endmodule

// File: tb/tb_redirection_ctrl_gen.sv
// Bench for redirection_ctrl_gen: directed MIPS sequences plus random traffic against an
// in-flight instruction list model (youngest producer search).
module tb_redirection_ctrl_gen;
    localparam int REG_W = 5;
    // Narrow counter so saturation is reachable in a few hundred cycles.
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_use_rs = 1'b0;
    logic             id_use_rt = 1'b0;
    logic             id_wr_en = 1'b0;
    logic [REG_W-1:0] id_wr_reg = '0;
    logic             id_is_load = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       redirection_ctrl;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    redirection_ctrl_gen #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
        .redirection_ctrl(redirection_ctrl), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit we;
        int wr;
        bit ld;
    } ins_t;

    ins_t q[$];          // q[0] = instruction in EX, q[1] = instruction in MEM
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    logic [3:0] exp_ctrl = 4'b0000;

    // 0: no producer in flight, 1: youngest producer is in EX (alu_out), 2: in MEM (mem_out)
    function automatic int src(int r, bit use_r, bit v);
        if (!v || !use_r || r == 0) return 0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].v && q[i].we && q[i].wr == r) return i + 1;
        return 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ins_t b;
        b = '{v: 0, we: 0, wr: 0, ld: 0};
        q = {};
        q.push_back(b);
        q.push_back(b);
        exp_cnt = 0;
    endtask

    // Present one ID instruction for one cycle; stl reports whether the model expected a stall.
    task automatic issue(bit v, int rs, int rt, bit urs, bit urt, bit we, int wr, bit ld,
                         bit fl, output bit stl);
        int   a, b;
        bit   st;
        ins_t n;
        id_valid = v; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0];
        id_use_rs = urs; id_use_rt = urt; id_wr_en = we; id_wr_reg = wr[REG_W-1:0];
        id_is_load = ld; flush = fl;
        a = src(rs, urs, v);
        b = src(rt, urt, v);
        st = !fl && (a == 1 || b == 1) && q[0].ld;
        @(negedge clk);
        chk("stall", {31'd0, stall}, {31'd0, st});
        if (st || fl) exp_ctrl = 4'b0000;
        else exp_ctrl = {b == 2, b == 1, a == 2, a == 1};
        if (st && exp_cnt < CNT_MAX) exp_cnt++;
        @(posedge clk);
        #1;
        if (st || fl) n = '{v: 0, we: 0, wr: 0, ld: 0};
        else n = '{v: v, we: we, wr: wr, ld: ld};
        q.push_front(n);
        void'(q.pop_back());
        chk("ctrl", {28'd0, redirection_ctrl}, {28'd0, exp_ctrl});
        chk("stall_count", {{(32-CNT_W){1'b0}}, stall_count}, exp_cnt);
        stl = st;
    endtask

    initial begin
        bit s;
        int cnt_before;
        model_clear();
        #12;
        chk("reset_ctrl", {28'd0, redirection_ctrl}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_cnt", {{(32-CNT_W){1'b0}}, stall_count}, 32'd0);
        rst_n = 1'b1;

        // EX forward on A, then on B
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0, s);           // add $3,$1,$2
        issue(1, 3, 5, 1, 1, 1, 4, 0, 0, s);           // sub $4,$3,$5
        chk("ex_fwd_a", {28'd0, redirection_ctrl}, 32'b0001);
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0, s);
        issue(1, 5, 3, 1, 1, 1, 4, 0, 0, s);           // sub $4,$5,$3
        chk("ex_fwd_b", {28'd0, redirection_ctrl}, 32'b0100);

        // MEM forward, then youngest-wins with rt=$0
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0, s);           // add $3
        issue(1, 1, 2, 1, 1, 1, 6, 0, 0, s);           // or  $6
        issue(1, 3, 3, 1, 1, 1, 7, 0, 0, s);           // and $7,$3,$3
        chk("mem_fwd", {28'd0, redirection_ctrl}, 32'b1010);
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0, s);
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0, s);
        issue(1, 3, 0, 1, 1, 1, 7, 0, 0, s);           // and $7,$3,$0
        chk("youngest_wins", {28'd0, redirection_ctrl}, 32'b0001);

        // Load-use: one bubble, then mem forward on both operands
        issue(1, 1, 0, 1, 0, 1, 8, 1, 0, s);           // lw $8,0($1)
        issue(1, 8, 8, 1, 1, 1, 9, 0, 0, s);           // add $9,$8,$8
        chk("lu_stall", {31'd0, s}, 32'd1);
        chk("lu_bubble", {28'd0, redirection_ctrl}, 32'b0000);
        issue(1, 8, 8, 1, 1, 1, 9, 0, 0, s);           // held and reissued
        chk("lu_nostall", {31'd0, s}, 32'd0);
        chk("lu_fwd", {28'd0, redirection_ctrl}, 32'b1010);
        chk("lu_count", {{(32-CNT_W){1'b0}}, stall_count}, 32'd1);

        // Flush beats stall
        issue(1, 1, 0, 1, 0, 1, 8, 1, 0, s);
        cnt_before = exp_cnt;
        issue(1, 8, 8, 1, 1, 1, 9, 0, 1, s);
        chk("flush_ctrl", {28'd0, redirection_ctrl}, 32'b0000);
        chk("flush_cnt", {{(32-CNT_W){1'b0}}, stall_count}, cnt_before);

        // Register 0 never forwards
        issue(1, 1, 0, 1, 0, 1, 0, 0, 0, s);           // addi $0,$1,imm
        issue(1, 0, 0, 1, 1, 1, 1, 0, 0, s);           // add $1,$0,$0
        chk("reg0", {28'd0, redirection_ctrl}, 32'b0000);

        // Asynchronous reset while a stall is being requested
        issue(1, 1, 0, 1, 0, 1, 8, 1, 0, s);
        id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_use_rs = 1; id_use_rt = 1;
        id_wr_en = 1; id_wr_reg = 5'd9; id_is_load = 0; flush = 0;
        #2;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ctrl", {28'd0, redirection_ctrl}, 32'd0);
        chk("rst_cnt", {{(32-CNT_W){1'b0}}, stall_count}, 32'd0);
        model_clear();
        #1;
        rst_n = 1'b1;

        // Saturation: chained dependent loads give one stall per two cycles
        issue(1, 1, 0, 1, 0, 1, 8, 1, 0, s);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            issue(1, 8, 0, 1, 0, 1, 8, 1, 0, s);       // lw $8,0($8): stalls
            issue(1, 8, 0, 1, 0, 1, 8, 1, 0, s);       // reissued after bubble
        end
        chk("saturate", {{(32-CNT_W){1'b0}}, stall_count}, CNT_MAX);

        // Random traffic; a stalled instruction is held and reissued
        for (int i = 0; i < 400; i++) begin
            bit v, urs, urt, we, ld, fl;
            int rs, rt, wr;
            v = ($urandom_range(0, 7) != 0);
            rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); wr = $urandom_range(0, 3);
            urs = $urandom_range(0, 1); urt = $urandom_range(0, 1);
            we = ($urandom_range(0, 3) != 0); ld = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) == 0);
            issue(v, rs, rt, urs, urt, we, wr, ld, fl, s);
            for (int k = 0; k < 3 && s; k++) begin
                fl = ($urandom_range(0, 9) == 0);
                issue(v, rs, rt, urs, urt, we, wr, ld, fl, s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/redirection_ctrl_gen.md
Name: redirection_ctrl_gen

Overview:
- Producer of the 4-bit forwarding select consumed by the EX-stage operand forwarding muxes in the 5-stage MIPS core.
- Keeps a shadow copy of the destination-register info for the EX and MEM stages.
- Compares the ID-stage source registers against that shadow and registers the resulting select so it is aligned with the instruction once it enters EX.
- Detects load-use hazards, requests a one-cycle stall, and counts stalls for performance debug.

Parameters:
- REG_W, 5, register-address width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source register A
- id_rt  in  REG_W  source register B
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  REG_W  destination register
- id_is_load  in  1  instruction is a load (result only valid at mem_out)
- flush  in  1  branch/jump taken; ID instruction is squashed
- redirection_ctrl  out  4  registered select for the EX stage:
  - bit0: A from alu_out
  - bit1: A from mem_out
  - bit2: B from alu_out
  - bit3: B from mem_out
  - the alu bit dominates when both bits for an operand are set
- stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow entries: ex_e and mem_e, each {valid, wr_en, wr_reg, is_load}.
- Reset (async, rst_n=0): ex_e and mem_e invalid, redirection_ctrl=4'b0000, stall_count=0. stall reads 0 while rst_n=0.
- Matches (combinational, ID vs shadow):
  - match_ex_X = id_valid & id_use_X & ex_e.valid & ex_e.wr_en & (ex_e.wr_reg==id_X) & (id_X!=0)
  - match_mem_X is the same expression using mem_e.
  - Register 0 never matches.
- stall = ~flush & ex_e.is_load & (match_ex_rs | match_ex_rt).
  - Load-use is exactly 1 bubble: the load's data is at mem_out one cycle later.
- Every rising edge (no enable; the pipeline always advances behind this block):
  - mem_e <= ex_e.
  - If flush or stall: ex_e <= invalid, redirection_ctrl <= 0.
  - Else:
    - ex_e <= {id_valid, id_wr_en, id_wr_reg, id_is_load}.
    - redirection_ctrl <= {match_mem_rt & ~match_ex_rt, match_ex_rt, match_mem_rs & ~match_ex_rs, match_ex_rs}.
    - Youngest producer wins; the alu and mem bits of one operand are never both set.
- Latency: select computed in ID, visible on redirection_ctrl for exactly the cycle the instruction is in EX.
- Stall hold: upstream holds ID inputs during stall. On the next edge the load is in mem_e, so the held instruction gets the mem bit and no further stall.
- Flush priority: flush overrides stall (stall=0). stall_count does not increment on flush.
- stall_count: increments by 1 each edge where stall=1. Saturates at all-ones and does not wrap.
- Bubbles (id_valid=0): always produce ctrl=0 and never match.
- WB-stage producers: not forwarded. The register file writes in the first half-cycle, so ID reads are already correct.
- Reset mid-stall: everything clears immediately, and stall drops asynchronously.

Test Plan:
- Reset: rst_n=0 mid-stream -> ctrl=0000, stall=0, stall_count=0 immediately, no clock needed.
- EX forward: `add $3,$1,$2` then `sub $4,$3,$5` -> stall=0; ctrl=0001 during sub's EX cycle. Swap operands (`sub $4,$5,$3`) -> 0100.
- MEM forward / priority: `add $3`, `or $6`, `and $7,$3,$3` -> ctrl=1010. Then `add $3`, `add $3`, `and $7,$3,$0` -> ctrl=0001 (youngest wins; rt=$0 gives no B bits).
- Load-use: `lw $8,0($1)` then `add $9,$8,$8` -> stall=1 for exactly one cycle, ctrl=0000 for the bubble, then ctrl=1010 for add's EX cycle; stall_count=1.
- Flush vs stall: load-use pair with flush=1 in the same cycle -> stall=0, ex_e invalid, ctrl=0000, stall_count unchanged.
- Register 0 and saturation: `addi $0,...` then `add $1,$0,$0` -> ctrl=0000. Drive 2^CNT_W+3 load-use stalls -> stall_count holds at 16'hFFFF.
